// File: rtl/issue_scheduler.sv
// In-order issue queue with a register scoreboard. The queue head is dispatched to
// the INT/LSU/VEC unit it selects once it is hazard-free and that unit is ready.
module issue_scheduler #(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             dec_valid_in,
  output logic             dec_ready_out,
  input  logic [2:0]       exec_unit_sel_in,
  input  logic [3:0]       exec_unit_uop_in,
  input  logic [4:0]       rd_in,
  input  logic [4:0]       rs1_in,
  input  logic [4:0]       rs2_in,
  input  logic             rd_we_in,
  input  logic             rs1_use_in,
  input  logic             rs2_use_in,
  input  logic [2:0]       unit_ready_in,
  output logic [2:0]       issue_valid_out,
  output logic [3:0]       issue_uop_out,
  output logic [4:0]       issue_rd_out,
  output logic [4:0]       issue_rs1_out,
  output logic [4:0]       issue_rs2_out,
  input  logic             wb_valid_in,
  input  logic [4:0]       wb_rd_in,
  input  logic             flush_in,
  output logic             exc_out,
  input  logic             exc_ack_in,
  output logic [CNT_W-1:0] stall_cnt_out
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned OCC_W = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] uop;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rd_we;
    logic       rs1_use;
    logic       rs2_use;
  } entry_t;

  typedef enum logic {RUN, HALT} state_t;

  state_t           state, state_nxt;
  logic             exc_nxt;
  entry_t           q [QDEPTH];
  entry_t           head;
  entry_t           enq_entry;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [31:0]      sb, sb_nxt;
  logic             head_valid, sel_ok, hazard, issue, exc_trig, stall, enq, empty_q;

  assign enq_entry = '{sel: exec_unit_sel_in, uop: exec_unit_uop_in, rd: rd_in,
                       rs1: rs1_in, rs2: rs2_in, rd_we: rd_we_in,
                       rs1_use: rs1_use_in, rs2_use: rs2_use_in};

  // Head decode, hazard check against the registered scoreboard, and issue select
  always_comb begin
    head_valid = (occ != '0);
    head       = head_valid ? q[rd_ptr] : '0;
    sel_ok     = (head.sel == 3'b001) || (head.sel == 3'b010) || (head.sel == 3'b100);
    hazard     = (head.rs1_use && sb[head.rs1]) || (head.rs2_use && sb[head.rs2]) ||
                 (head.rd_we && sb[head.rd]);
    issue      = head_valid && (state == RUN) && sel_ok && !hazard &&
                 ((unit_ready_in & head.sel) != 3'b000);
    exc_trig   = head_valid && (state == RUN) && !sel_ok;
    stall      = head_valid && (state == RUN) && sel_ok && !issue;
    enq        = dec_valid_in && dec_ready_out;
    empty_q    = flush_in || exc_trig;
  end

  assign dec_ready_out   = !rst_in && (state == RUN) && (occ < OCC_W'(QDEPTH));
  assign issue_valid_out = issue ? head.sel : 3'b000;
  assign issue_uop_out   = head.uop;
  assign issue_rd_out    = head.rd;
  assign issue_rs1_out   = head.rs1;
  assign issue_rs2_out   = head.rs2;

  // RUN/HALT control; flush overrides exception entry
  always_comb begin
    state_nxt = state;
    exc_nxt   = exc_out;
    if (flush_in) begin
      state_nxt = RUN;
      exc_nxt   = 1'b0;
    end else if (state == RUN && exc_trig) begin
      state_nxt = HALT;
      exc_nxt   = 1'b1;
    end else if (state == HALT && exc_ack_in) begin
      state_nxt = RUN;
      exc_nxt   = 1'b0;
    end
  end

  // Issue-time set wins over a same-cycle writeback clear; x0 is never pending
  always_comb begin
    sb_nxt = sb;
    if (wb_valid_in) sb_nxt[wb_rd_in] = 1'b0;
    if (issue && head.rd_we && head.rd != 5'd0) sb_nxt[head.rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= RUN;
      exc_out       <= 1'b0;
      sb            <= '0;
      stall_cnt_out <= '0;
    end else begin
      state   <= state_nxt;
      exc_out <= exc_nxt;
      sb      <= sb_nxt;
      if (stall && stall_cnt_out != {CNT_W{1'b1}}) stall_cnt_out <= stall_cnt_out + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (empty_q) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, issue})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy alone decides validity
  always_ff @(posedge clk_in) begin
    if (enq && !empty_q) q[wr_ptr] <= enq_entry;
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: dispatch, hazards, backpressure, exceptions,
// flush and asynchronous reset, with hand-computed expectations.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready;
  logic [2:0]  sel;
  logic [3:0]  uop;
  logic [4:0]  rd, rs1, rs2;
  logic        rd_we, rs1_use, rs2_use;
  logic [2:0]  unit_ready, issue_valid;
  logic [3:0]  issue_uop;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush, exc, exc_ack;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  issue_scheduler #(.QDEPTH(2), .CNT_W(16)) dut (
    .clk_in(clk), .rst_in(rst),
    .dec_valid_in(dec_valid), .dec_ready_out(dec_ready),
    .exec_unit_sel_in(sel), .exec_unit_uop_in(uop),
    .rd_in(rd), .rs1_in(rs1), .rs2_in(rs2),
    .rd_we_in(rd_we), .rs1_use_in(rs1_use), .rs2_use_in(rs2_use),
    .unit_ready_in(unit_ready), .issue_valid_out(issue_valid),
    .issue_uop_out(issue_uop), .issue_rd_out(issue_rd),
    .issue_rs1_out(issue_rs1), .issue_rs2_out(issue_rs2),
    .wb_valid_in(wb_valid), .wb_rd_in(wb_rd), .flush_in(flush),
    .exc_out(exc), .exc_ack_in(exc_ack), .stall_cnt_out(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] s, input logic [3:0] u, input logic [4:0] d,
                       input logic [4:0] a, input logic [4:0] b, input logic we,
                       input logic ua, input logic ub);
    dec_valid = 1'b1; sel = s; uop = u; rd = d; rs1 = a; rs2 = b;
    rd_we = we; rs1_use = ua; rs2_use = ub;
    #1;
  endtask

  task automatic idle();
    dec_valid = 1'b0; sel = 3'b000; uop = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    rd_we = 1'b0; rs1_use = 1'b0; rs2_use = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; unit_ready = 3'b111; wb_valid = 1'b0; wb_rd = 5'd0;
    flush = 1'b0; exc_ack = 1'b0;
    idle();
    chk("rst_ready", 32'(dec_ready), 32'd0);
    chk("rst_issue", 32'(issue_valid), 32'd0);
    chk("rst_exc", 32'(exc), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    tick(); tick();
    rst = 1'b0; #1;
    chk("post_rst_ready", 32'(dec_ready), 32'd1);
    chk("empty_rd", 32'(issue_rd), 32'd0);

    // ADD rd=5 issues one cycle after enqueue
    offer(3'b001, 4'd1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
    chk("add_no_bypass", 32'(issue_valid), 32'd0);
    tick(); idle();
    chk("add_issue", 32'(issue_valid), 32'b001);
    chk("add_rd", 32'(issue_rd), 32'd5);
    chk("add_uop", 32'(issue_uop), 32'd1);
    tick();
    chk("add_popped", 32'(issue_valid), 32'd0);

    // Dependent SUB stalls on sb[5] until writeback
    offer(3'b001, 4'd2, 5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    chk("sub_stall0", 32'(issue_valid), 32'd0);
    tick();
    chk("sub_stall_cnt1", 32'(stall_cnt), 32'd1);
    tick();
    chk("sub_stall_cnt2", 32'(stall_cnt), 32'd2);
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
    chk("sub_no_wb_bypass", 32'(issue_valid), 32'd0);
    tick(); wb_valid = 1'b0; #1;
    chk("sub_issue", 32'(issue_valid), 32'b001);
    chk("sub_rs1", 32'(issue_rs1), 32'd5);
    chk("sub_stall_cnt3", 32'(stall_cnt), 32'd3);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd6; tick(); wb_valid = 1'b0;

    // LSU not ready: queue fills, third offer refused
    unit_ready = 3'b101;
    offer(3'b010, 4'd3, 5'd8, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    offer(3'b010, 4'd3, 5'd9, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    chk("lsu_ready_occ1", 32'(dec_ready), 32'd1);
    chk("lsu_blocked", 32'(issue_valid), 32'd0);
    tick();
    offer(3'b010, 4'd3, 5'd10, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
    chk("lsu_full", 32'(dec_ready), 32'd0);
    tick(); idle();
    chk("lsu_stall_cnt", 32'(stall_cnt), 32'd5);
    unit_ready = 3'b111; #1;
    chk("lb1_issue", 32'(issue_valid), 32'b010);
    chk("lb1_rd", 32'(issue_rd), 32'd8);
    tick();
    chk("lb2_issue", 32'(issue_valid), 32'b010);
    chk("lb2_rd", 32'(issue_rd), 32'd9);
    tick();
    chk("lsu_drained", 32'(issue_valid), 32'd0);
    chk("lsu_no_third", 32'(issue_rd), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd8; tick(); wb_rd = 5'd9; tick(); wb_valid = 1'b0;

    // Invalid sel=000 raises a held exception and halts intake
    offer(3'b000, 4'd4, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    chk("inv_no_issue", 32'(issue_valid), 32'd0);
    chk("inv_exc_pre", 32'(exc), 32'd0);
    tick();
    chk("inv_exc", 32'(exc), 32'd1);
    chk("inv_halt_ready", 32'(dec_ready), 32'd0);
    chk("inv_emptied", 32'(issue_rd), 32'd0);
    chk("inv_no_stall", 32'(stall_cnt), 32'd5);
    tick();
    chk("inv_exc_held", 32'(exc), 32'd1);
    exc_ack = 1'b1; tick(); exc_ack = 1'b0; #1;
    chk("ack_exc", 32'(exc), 32'd0);
    chk("ack_ready", 32'(dec_ready), 32'd1);

    // Same-cycle issue and writeback of rd=7: set wins
    offer(3'b001, 4'd5, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    wb_valid = 1'b1; wb_rd = 5'd7; #1;
    chk("r7_issue", 32'(issue_valid), 32'b001);
    tick(); wb_valid = 1'b0;
    offer(3'b001, 4'd6, 5'd0, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    chk("r7_pending", 32'(issue_valid), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd7; tick(); wb_valid = 1'b0; #1;
    chk("r7_reader_issue", 32'(issue_valid), 32'b001);
    chk("r7_stall_cnt", 32'(stall_cnt), 32'd6);
    tick();
    offer(3'b100, 4'd7, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    tick(); idle();
    chk("x0_reader_issue", 32'(issue_valid), 32'b100);
    tick();

    // Flush with two queued and a simultaneous offer
    unit_ready = 3'b000;
    offer(3'b001, 4'd8, 5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    offer(3'b001, 4'd9, 5'd12, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    offer(3'b001, 4'd10, 5'd13, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("flush_full", 32'(dec_ready), 32'd0);
    flush = 1'b1;
    tick(); flush = 1'b0; idle();
    chk("flush_ready", 32'(dec_ready), 32'd1);
    chk("flush_empty", 32'(issue_rd), 32'd0);
    chk("flush_stall_kept", 32'(stall_cnt), 32'd8);
    unit_ready = 3'b111; tick();
    chk("flush_dropped", 32'(issue_valid), 32'd0);

    // Asynchronous reset mid-stall
    unit_ready = 3'b000;
    offer(3'b001, 4'd1, 5'd14, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle(); tick();
    chk("pre_rst_stall", 32'(stall_cnt), 32'd9);
    rst = 1'b1; #1;
    chk("async_stall", 32'(stall_cnt), 32'd0);
    chk("async_issue", 32'(issue_valid), 32'd0);
    chk("async_ready", 32'(dec_ready), 32'd0);
    #1 rst = 1'b0;
    unit_ready = 3'b111;
    tick();
    offer(3'b011, 4'd1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle(); tick();
    chk("pre_rst_exc", 32'(exc), 32'd1);
    rst = 1'b1; #1;
    chk("async_exc", 32'(exc), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("rst_run_ready", 32'(dec_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
